adc_spi_responder: RTL and testbench

- SPI responder (peripheral end) matching our spi_con controller; emulates one serial ADC channel (AD747x-style framing) inside the fabric.
- Samples queued from the system side are shifted out on cipo while the controller drives dclk/cs.
- Used for loopback/hardware-in-loop bring-up of the receive chain (spi_con -> receive_beamformer -> echo detect) without real transducers.

---
 rtl/sonic_spi_pkg.sv | 26 ++
 rtl/spi_edge_detect.sv | 65 ++++++
 rtl/adc_spi_responder.sv | 219 +++++++++++++++++++++
 tb/tb_adc_spi_responder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sonic_spi_pkg.sv
// Shared types and defaults for the SPI ADC-emulation blocks.
//
// Contents:
//   spi_resp_state_t  responder frame state (IDLE, SHIFT, DONE)
//   SPI_DATA_WIDTH    default sample width, matches ADC_DATA_WIDTH
//   SPI_IDLE_LEVEL    default cipo level outside a frame
//   SPI_SYNC_DEPTH    synchronizer depth used when input sync is enabled
//   spi_frame_len()   frame length in dclk periods

package sonic_spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } spi_resp_state_t;

  localparam int   SPI_DATA_WIDTH = 16;
  localparam logic SPI_IDLE_LEVEL = 1'b0;
  localparam int   SPI_SYNC_DEPTH = 2;

  function automatic int spi_frame_len(input int lead_zeros, input int data_width);
    return lead_zeros + data_width;
  endfunction

endpackage

// File: rtl/spi_edge_detect.sv
// Conditions one slow control input (sclk or cs) into the clk_in domain and
// flags its edges. With SYNC_DEPTH = 0 the input is used directly and only a
// previous-value register is added; with SYNC_DEPTH > 0 it first passes
// through a flop chain.
//
// Ports:
//   clk_in   system clock
//   rst_n    synchronous reset, active-low
//   sig_in   raw input
//   level    conditioned level
//   rise     1-cycle pulse on a conditioned 0->1 transition
//   fall     1-cycle pulse on a conditioned 1->0 transition
//
// Parameters:
//   SYNC_DEPTH  synchronizer flops before edge detection (0 or 2)
//   RST_VAL     idle level of the input, loaded on reset so that releasing
//               reset with the input at its idle level raises no edge

module spi_edge_detect #(
  parameter int   SYNC_DEPTH = 0,
  parameter logic RST_VAL    = 1'b0
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic sig_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic level_q;

  generate
    if (SYNC_DEPTH > 0) begin : g_sync
      logic [SYNC_DEPTH-1:0] sync_q;

      always_ff @(posedge clk_in) begin
        if (!rst_n) begin
          sync_q <= {SYNC_DEPTH{RST_VAL}};
        end else begin
          sync_q[0] <= sig_in;
          for (int i = 1; i < SYNC_DEPTH; i++) begin
            sync_q[i] <= sync_q[i-1];
          end
        end
      end

      assign level = sync_q[SYNC_DEPTH-1];
    end else begin : g_direct
      assign level = sig_in;
    end
  endgenerate

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      level_q <= RST_VAL;
    end else begin
      level_q <= level;
    end
  end

  assign rise = level & ~level_q;
  assign fall = ~level & level_q;

endmodule

// File: rtl/adc_spi_responder.sv
// SPI responder that emulates one AD747x-style serial ADC channel inside the
// fabric. Samples pushed from the system side are shifted out MSB first on
// cipo while the controller (spi_con) drives dclk and cs. Used for loopback
// bring-up of the receive chain without real transducers.
//
// Ports:
//   clk_in            system clock (100 MHz)
//   rst_n             synchronous reset, active-low
//   sclk_in           dclk from the controller
//   cs_in             chip select from the controller, active-low
//   sample_in         next sample to transmit
//   sample_valid_in   sample_in is valid
//   sample_ready_out  holding buffer empty; push on valid && ready
//   cipo_out          serial data to the controller
//   cipo_oe_out       high while a frame is active (pin tristate enable)
//   frame_done_out    1-cycle pulse after the last bit is shifted
//   abort_out         1-cycle pulse when cs rises mid-frame
//   underrun_out      1-cycle pulse when a frame starts with the buffer empty
//
// Build option:
//   ADC_SPI_RESPONDER_SYNC_EN  when defined, sclk_in and cs_in pass through a
//                              2-FF synchronizer (2 cycles extra edge latency,
//                              dclk high/low >= 4 clk_in cycles). When
//                              undefined, edges are detected directly for
//                              same-clock loopback (high/low >= 2 cycles).
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no frame; cipo at IDLE_LEVEL, pin released, sclk ignored
// SHIFT | frame active; current frame bit on cipo, advance on sclk fall
// DONE  | all bits sent; cipo at IDLE_LEVEL, pin driven until cs rises

module adc_spi_responder
  import sonic_spi_pkg::*;
#(
  parameter int   DATA_WIDTH = SPI_DATA_WIDTH,
  parameter int   LEAD_ZEROS = 0,
  parameter logic IDLE_LEVEL = SPI_IDLE_LEVEL
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic                  sclk_in,
  input  logic                  cs_in,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid_in,
  output logic                  sample_ready_out,
  output logic                  cipo_out,
  output logic                  cipo_oe_out,
  output logic                  frame_done_out,
  output logic                  abort_out,
  output logic                  underrun_out
);

  localparam int FRAME_LEN = spi_frame_len(LEAD_ZEROS, DATA_WIDTH);
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] FRAME_LEN_C = CNT_W'(FRAME_LEN);

`ifdef ADC_SPI_RESPONDER_SYNC_EN
  localparam int IN_SYNC_DEPTH = SPI_SYNC_DEPTH;
`else
  localparam int IN_SYNC_DEPTH = 0;
`endif

  logic sclk_level, sclk_rise, sclk_fall;
  logic cs_level, cs_rise, cs_fall;

  spi_edge_detect #(
    .SYNC_DEPTH (IN_SYNC_DEPTH),
    .RST_VAL    (1'b0)
  ) u_sclk_edge (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .sig_in (sclk_in),
    .level  (sclk_level),
    .rise   (sclk_rise),
    .fall   (sclk_fall)
  );

  spi_edge_detect #(
    .SYNC_DEPTH (IN_SYNC_DEPTH),
    .RST_VAL    (1'b1)
  ) u_cs_edge (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .sig_in (cs_in),
    .level  (cs_level),
    .rise   (cs_rise),
    .fall   (cs_fall)
  );

  // Levels and the sclk rising edge are not needed: the controller samples
  // on the rising edge, the responder only acts on the falling one.
  logic unused_edge_sigs;
  assign unused_edge_sigs = ^{sclk_level, sclk_rise, cs_level};

  spi_resp_state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] buf_q;
  logic                  buf_full;
  logic [DATA_WIDTH-1:0] last_q;
  logic [FRAME_LEN-1:0]  shift_q;
  logic [CNT_W-1:0]      bit_cnt;
  logic [CNT_W-1:0]      bit_cnt_inc;
  logic [FRAME_LEN-1:0]  load_word;

  logic push, pop;
  logic load, cnt_en, shift_en;
  logic done_set, abort_set, under_set;
  logic done_q, abort_q, under_q;

  assign bit_cnt_inc = bit_cnt + 1'b1;
  assign push        = sample_valid_in && !buf_full;
  assign pop         = load && buf_full;

  // Zero-extension places the LEAD_ZEROS zeros ahead of the sample MSB.
  // An empty buffer replays the last transmitted sample.
  assign load_word = FRAME_LEN'(buf_full ? buf_q : last_q);

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    cnt_en    = 1'b0;
    shift_en  = 1'b0;
    done_set  = 1'b0;
    abort_set = 1'b0;
    under_set = 1'b0;

    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_nxt = SHIFT;
          load      = 1'b1;
          under_set = !buf_full;
        end
      end

      SHIFT: begin
        // cs rising wins over a coincident sclk fall.
        if (cs_rise) begin
          state_nxt = IDLE;
          abort_set = 1'b1;
        end else if (sclk_fall) begin
          cnt_en = 1'b1;
          if (bit_cnt_inc == FRAME_LEN_C) begin
            state_nxt = DONE;
            done_set  = 1'b1;
          end else begin
            shift_en = 1'b1;
          end
        end
      end

      DONE: begin
        if (cs_rise) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      buf_q    <= '0;
      buf_full <= 1'b0;
      last_q   <= '0;
      shift_q  <= '0;
      bit_cnt  <= '0;
      done_q   <= 1'b0;
      abort_q  <= 1'b0;
      under_q  <= 1'b0;
    end else begin
      done_q  <= done_set;
      abort_q <= abort_set;
      under_q <= under_set;

      // push only happens while empty and pop only while full, so they are
      // mutually exclusive.
      if (push) begin
        buf_q    <= sample_in;
        buf_full <= 1'b1;
      end else if (pop) begin
        buf_full <= 1'b0;
      end

      if (load) begin
        shift_q <= load_word;
        bit_cnt <= '0;
        if (buf_full) begin
          last_q <= buf_q;
        end
      end else if (cnt_en) begin
        bit_cnt <= bit_cnt_inc;
        if (shift_en) begin
          shift_q <= shift_q << 1;
        end
      end
    end
  end

  assign sample_ready_out = !buf_full;
  assign cipo_out         = (state == SHIFT) ? shift_q[FRAME_LEN-1] : IDLE_LEVEL;
  assign cipo_oe_out      = (state != IDLE);
  assign frame_done_out   = done_q;
  assign abort_out        = abort_q;
  assign underrun_out     = under_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
module tb_adc_spi_responder;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;

  // DUT A: default 16-bit frame
  logic        sclk_a = 1'b0;
  logic        cs_a = 1'b1;
  logic [15:0] sample_a = '0;
  logic        valid_a = 1'b0;
  logic        ready_a, cipo_a, oe_a, done_a, abort_a, under_a;

  // DUT B: 4 lead zeros + 12-bit sample
  logic        sclk_b = 1'b0;
  logic        cs_b = 1'b1;
  logic [11:0] sample_b = '0;
  logic        valid_b = 1'b0;
  logic        ready_b, cipo_b, oe_b, done_b, abort_b, under_b;

  always #5 clk_in = ~clk_in;

  adc_spi_responder u_dut_a (
    .clk_in           (clk_in),
    .rst_n            (rst_n),
    .sclk_in          (sclk_a),
    .cs_in            (cs_a),
    .sample_in        (sample_a),
    .sample_valid_in  (valid_a),
    .sample_ready_out (ready_a),
    .cipo_out         (cipo_a),
    .cipo_oe_out      (oe_a),
    .frame_done_out   (done_a),
    .abort_out        (abort_a),
    .underrun_out     (under_a)
  );

  adc_spi_responder #(
    .DATA_WIDTH (12),
    .LEAD_ZEROS (4)
  ) u_dut_b (
    .clk_in           (clk_in),
    .rst_n            (rst_n),
    .sclk_in          (sclk_b),
    .cs_in            (cs_b),
    .sample_in        (sample_b),
    .sample_valid_in  (valid_b),
    .sample_ready_out (ready_b),
    .cipo_out         (cipo_b),
    .cipo_oe_out      (oe_b),
    .frame_done_out   (done_b),
    .abort_out        (abort_b),
    .underrun_out     (under_b)
  );

  // Free-running pulse counters; tests compare differences across a frame.
  int done_a_n = 0, abort_a_n = 0, under_a_n = 0;
  int done_b_n = 0, abort_b_n = 0, under_b_n = 0;

  always @(negedge clk_in) begin
    if (done_a)  done_a_n++;
    if (abort_a) abort_a_n++;
    if (under_a) under_a_n++;
    if (done_b)  done_b_n++;
    if (abort_b) abort_b_n++;
    if (under_b) under_b_n++;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // spi_con-style dclk: 3 cycles high, 2 low; cipo captured as dclk rises.
  task automatic shift_a(input int n, output logic [15:0] cap);
    cap = '0;
    for (int i = 0; i < n; i++) begin
      sclk_a = 1'b1;
      cap = {cap[14:0], cipo_a};
      tick(); tick(); tick();
      sclk_a = 1'b0;
      tick(); tick();
    end
  endtask

  task automatic shift_b(input int n, output logic [15:0] cap);
    cap = '0;
    for (int i = 0; i < n; i++) begin
      sclk_b = 1'b1;
      cap = {cap[14:0], cipo_b};
      tick(); tick(); tick();
      sclk_b = 1'b0;
      tick(); tick();
    end
  endtask

  task automatic push_a(input logic [15:0] v);
    sample_a = v;
    valid_a  = 1'b1;
    tick();
    valid_a  = 1'b0;
  endtask

  typedef struct {
    bit          push_en;
    logic [15:0] push_val;
    int          falls;
    logic [15:0] exp_cap;
    int          exp_done;
    int          exp_under;
    int          exp_abort;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [15:0] cap;
    int b_done, b_abort, b_under;

    vecs[0] = '{1'b1, 16'hA5C3, 16, 16'hA5C3, 1, 0, 0};  // normal frame
    vecs[1] = '{1'b0, 16'h0000, 16, 16'hA5C3, 1, 1, 0};  // underrun replays last
    vecs[2] = '{1'b1, 16'hF0F0,  7, 16'h0078, 0, 0, 1};  // abort after 7 falls
    vecs[3] = '{1'b1, 16'h1234, 16, 16'h1234, 1, 0, 0};  // fresh sample after abort

    // Reset state
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("rst_ready_a", ready_a, 1);
    check("rst_cipo_a",  cipo_a,  0);
    check("rst_oe_a",    oe_a,    0);
    check("rst_pulses_a", {done_a, abort_a, under_a}, 0);
    check("rst_ready_b", ready_b, 1);
    check("rst_oe_b",    oe_b,    0);

    // Table-driven frames on DUT A
    for (int v = 0; v < 4; v++) begin
      if (vecs[v].push_en) begin
        push_a(vecs[v].push_val);
        check($sformatf("v%0d_ready_after_push", v), ready_a, 0);
      end
      b_done  = done_a_n;
      b_abort = abort_a_n;
      b_under = under_a_n;
      cs_a = 1'b0;
      tick();
      check($sformatf("v%0d_oe_start", v), oe_a, 1);
      check($sformatf("v%0d_ready_start", v), ready_a, 1);
      shift_a(vecs[v].falls, cap);
      cs_a = 1'b1;
      tick();
      check($sformatf("v%0d_oe_end", v), oe_a, 0);
      tick(); tick();
      check($sformatf("v%0d_capture", v), cap, vecs[v].exp_cap);
      check($sformatf("v%0d_done_cnt", v), done_a_n - b_done, vecs[v].exp_done);
      check($sformatf("v%0d_under_cnt", v), under_a_n - b_under, vecs[v].exp_under);
      check($sformatf("v%0d_abort_cnt", v), abort_a_n - b_abort, vecs[v].exp_abort);
    end

    // Backpressure: second sample waits until the first is popped
    push_a(16'h0001);
    sample_a = 16'h0002;
    valid_a  = 1'b1;
    tick(); tick();
    check("bp_ready_held", ready_a, 0);
    cs_a = 1'b0;
    tick();
    check("bp_ready_at_pop", ready_a, 1);
    tick();
    check("bp_second_accepted", ready_a, 0);
    valid_a = 1'b0;
    shift_a(16, cap);
    check("bp_frame1", cap, 16'h0001);
    cs_a = 1'b1;
    tick(); tick();
    b_under = under_a_n;
    cs_a = 1'b0;
    tick();
    shift_a(16, cap);
    check("bp_frame2", cap, 16'h0002);
    cs_a = 1'b1;
    tick(); tick();
    check("bp_no_underrun", under_a_n - b_under, 0);

    // Lead zeros on DUT B, extra dclk in DONE
    sample_b = 12'hFFF;
    valid_b  = 1'b1;
    tick();
    valid_b  = 1'b0;
    check("lz_ready_after_push", ready_b, 0);
    b_done = done_b_n;
    cs_b = 1'b0;
    tick();
    shift_b(16, cap);
    check("lz_capture", cap, 16'h0FFF);
    check("lz_done_cnt", done_b_n - b_done, 1);
    for (int i = 0; i < 2; i++) begin
      sclk_b = 1'b1;
      check($sformatf("lz_done_cipo_hi%0d", i), cipo_b, 0);
      tick(); tick(); tick();
      sclk_b = 1'b0;
      tick(); tick();
      check($sformatf("lz_done_cipo_lo%0d", i), cipo_b, 0);
      check($sformatf("lz_done_oe%0d", i), oe_b, 1);
    end
    check("lz_done_cnt_after_extra", done_b_n - b_done, 1);
    cs_b = 1'b1;
    tick();
    check("lz_oe_end", oe_b, 0);
    tick();
    check("lz_no_abort_under", abort_b_n + under_b_n, 0);

    // Reset mid-SHIFT
    push_a(16'hBEEF);
    cs_a = 1'b0;
    tick();
    shift_a(5, cap);
    check("rs_oe_before", oe_a, 1);
    b_abort = abort_a_n;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    cs_a  = 1'b1;
    check("rs_oe", oe_a, 0);
    check("rs_ready", ready_a, 1);
    check("rs_cipo", cipo_a, 0);
    tick(); tick();
    check("rs_oe_after", oe_a, 0);
    check("rs_no_abort", abort_a_n - b_abort, 0);
    // Buffer and last-sample cleared: next frame underruns and sends zeros
    b_under = under_a_n;
    cs_a = 1'b0;
    tick();
    shift_a(16, cap);
    check("rs_next_capture", cap, 16'h0000);
    check("rs_next_underrun", under_a_n - b_under, 1);
    cs_a = 1'b1;
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
